// File: rtl/lorenz_stepper.sv
// lorenz_stepper: time-multiplexed forward-Euler integrator for the Lorenz
// system in signed fixed point (WIDTH bits total, FRAC fractional bits).
// One shared signed multiplier is sequenced by an FSM: PREP computes rho*dt,
// MUL produces seven products (one per cycle), and UPD commits the new state.
// All arithmetic saturates; any saturation sets the sticky sat_flag.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            run control (start sampled in IDLE; abort wins)
//   init_x/y/z              initial state, latched on accepted start
//   sigma, beta, rho, dt    coefficients, latched on accepted start
//   num_steps               steps per run (0 = free-run until abort)
//   x_out, y_out, z_out     current state
//   out_valid               one-cycle pulse per committed step
//   busy, done              run in progress / normal completion pulse
//   step_cnt                completed steps in this run
//   sat_flag                sticky saturation indicator
module lorenz_stepper #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 20,
  parameter int STEP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [WIDTH-1:0]  init_x,
  input  logic signed [WIDTH-1:0]  init_y,
  input  logic signed [WIDTH-1:0]  init_z,
  input  logic signed [WIDTH-1:0]  sigma,
  input  logic signed [WIDTH-1:0]  beta,
  input  logic signed [WIDTH-1:0]  rho,
  input  logic signed [WIDTH-1:0]  dt,
  input  logic        [STEP_W-1:0] num_steps,
  output logic signed [WIDTH-1:0]  x_out,
  output logic signed [WIDTH-1:0]  y_out,
  output logic signed [WIDTH-1:0]  z_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic        [STEP_W-1:0] step_cnt,
  output logic                     sat_flag
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MUL  = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {saturated, result} for a WIDTH-bit saturating add or subtract.
  function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic sub);
    logic [WIDTH:0] s;
    s = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
            : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MIN_V : MAX_V)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic signed [WIDTH-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic signed [WIDTH-1:0] sigma_q, beta_q, rho_q, dt_q;
  logic [STEP_W-1:0] nsteps_q, step_q, step_d;
  logic signed [WIDTH-1:0] rdt_q, a_q, b_q, c_q, dx_q, p_q, q_q, r_q;
  logic sat_q, sat_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic accept;

  // Shared multiplier and the operand subtractor feeding it in k3/k4.
  logic signed [WIDTH-1:0]   mul_a, mul_b, mul_res, sub_l, sub_r;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-FRAC:0]       prod_hi;
  logic                      mul_sat;
  logic [WIDTH:0]            sub_v, xs, t1, ys, t2, zs;
  logic                      unused_prod_lsbs;

  assign accept = (state_q == S_IDLE) && start && !abort;

  assign sub_l = (k_q == 3'd4) ? rdt_q : a_q;
  assign sub_r = (k_q == 3'd4) ? c_q   : b_q;
  assign sub_v = sat_add(sub_l, sub_r, 1'b1);

  always_comb begin
    mul_a = y_q;
    mul_b = dt_q;
    if (state_q == S_PREP) begin
      mul_a = rho_q;
    end else begin
      case (k_q)
        3'd1:    mul_a = x_q;
        3'd2:    mul_a = z_q;
        3'd3:    begin mul_a = sigma_q; mul_b = sub_v[WIDTH-1:0]; end
        3'd4:    begin mul_a = x_q;     mul_b = sub_v[WIDTH-1:0]; end
        3'd5:    begin mul_a = x_q;     mul_b = a_q;              end
        3'd6:    begin mul_a = beta_q;  mul_b = c_q;              end
        default: mul_a = y_q;
      endcase
    end
  end

  // Keep product bits [FRAC+WIDTH-1:FRAC]; the bits above must all echo its sign.
  assign prod             = mul_a * mul_b;
  assign prod_hi          = prod[2*WIDTH-1:FRAC+WIDTH-1];
  assign mul_sat          = !((&prod_hi) || !(|prod_hi));
  assign mul_res          = mul_sat ? (prod[2*WIDTH-1] ? MIN_V : MAX_V)
                                    : prod[FRAC+WIDTH-1:FRAC];
  assign unused_prod_lsbs = ^prod[FRAC-1:0];

  assign xs = sat_add(x_q, dx_q, 1'b0);
  assign t1 = sat_add(p_q, a_q, 1'b1);
  assign ys = sat_add(y_q, t1[WIDTH-1:0], 1'b0);
  assign t2 = sat_add(q_q, r_q, 1'b1);
  assign zs = sat_add(z_q, t2[WIDTH-1:0], 1'b0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    step_d  = step_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_PREP;
        x_d     = init_x;
        y_d     = init_y;
        z_d     = init_z;
        step_d  = '0;
        sat_d   = 1'b0;
      end
      S_PREP: begin
        sat_d   = sat_q | mul_sat;
        state_d = S_MUL;
        k_d     = '0;
      end
      S_MUL: begin
        sat_d = sat_q | mul_sat | (((k_q == 3'd3) || (k_q == 3'd4)) & sub_v[WIDTH]);
        if (k_q == 3'd6) state_d = S_UPD;
        else             k_d = k_q + 3'd1;
      end
      S_UPD: begin
        x_d     = xs[WIDTH-1:0];
        y_d     = ys[WIDTH-1:0];
        z_d     = zs[WIDTH-1:0];
        sat_d   = sat_q | xs[WIDTH] | t1[WIDTH] | ys[WIDTH] | t2[WIDTH] | zs[WIDTH];
        step_d  = step_q + STEP_W'(1);
        valid_d = 1'b1;
        k_d     = '0;
        if ((nsteps_q != '0) && (step_d == nsteps_q)) state_d = S_DONE;
        else                                          state_d = S_MUL;
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = !abort;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides the next state only; a coincident UPD commit still lands.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      step_q   <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sigma_q  <= '0;
      beta_q   <= '0;
      rho_q    <= '0;
      dt_q     <= '0;
      nsteps_q <= '0;
      rdt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      dx_q     <= '0;
      p_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      step_q  <= step_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        sigma_q  <= sigma;
        beta_q   <= beta;
        rho_q    <= rho;
        dt_q     <= dt;
        nsteps_q <= num_steps;
      end
      if (state_q == S_PREP) rdt_q <= mul_res;
      if (state_q == S_MUL) begin
        case (k_q)
          3'd0:    a_q  <= mul_res;
          3'd1:    b_q  <= mul_res;
          3'd2:    c_q  <= mul_res;
          3'd3:    dx_q <= mul_res;
          3'd4:    p_q  <= mul_res;
          3'd5:    q_q  <= mul_res;
          3'd6:    r_q  <= mul_res;
          default: ;
        endcase
      end
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign step_cnt  = step_q;
  assign sat_flag  = sat_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lorenz_stepper.sv
module tb_lorenz_stepper;
  localparam int W  = 27;
  localparam int F  = 20;
  localparam int SW = 16;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));
  localparam longint ONE  = longint'(1) <<< F;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic signed [W-1:0] init_x = '0, init_y = '0, init_z = '0;
  logic signed [W-1:0] sigma = '0, beta = '0, rho = '0, dt = '0;
  logic [SW-1:0] num_steps = '0;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic out_valid, busy, done, sat_flag;
  logic [SW-1:0] step_cnt;

  lorenz_stepper #(.WIDTH(W), .FRAC(F), .STEP_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt), .num_steps(num_steps),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .out_valid(out_valid), .busy(busy), .done(done),
    .step_cnt(step_cnt), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  typedef struct {
    int     cyc;
    longint x, y, z;
    int     step;
    bit     sat;
  } exp_t;

  exp_t sbq[$];
  int   dq[$];

  // Bit-exact fixed-point reference: values held as integers scaled by 2^F.
  bit     msat;
  longint mx, my, mz, mrdt, msig, mbet, mdt;

  function automatic longint clampv(input longint v);
    if (v > MAXV) begin msat = 1'b1; return MAXV; end
    if (v < MINV) begin msat = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return clampv((a * b) >>> F);
  endfunction

  function automatic longint fadd(input longint a, input longint b);
    return clampv(a + b);
  endfunction

  function automatic longint fsub(input longint a, input longint b);
    return clampv(a - b);
  endfunction

  task automatic model_step();
    longint a, b, c, dx, p, q, r;
    a  = fmul(my, mdt);
    b  = fmul(mx, mdt);
    c  = fmul(mz, mdt);
    dx = fmul(msig, fsub(a, b));
    p  = fmul(mx, fsub(mrdt, c));
    q  = fmul(mx, a);
    r  = fmul(mbet, c);
    mx = fadd(mx, dx);
    my = fadd(my, fsub(p, a));
    mz = fadd(mz, fsub(q, r));
  endtask

  // Monitor: every out_valid / done pulse is matched against the scoreboard.
  exp_t me;
  int   dcy;
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        me = sbq.pop_front();
        chk("ov_cycle", cyc, me.cyc);
        chk("ov_x", x_out, me.x);
        chk("ov_y", y_out, me.y);
        chk("ov_z", z_out, me.z);
        chk("ov_step", step_cnt, me.step);
        chk("ov_sat", sat_flag, me.sat);
      end
    end
    if (reset_n && done) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        dcy = dq.pop_front();
        chk("done_cycle", cyc, dcy);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Starts one run, queues the expected samples, and drives abort / a stray
  // mid-run start at the given cycle offsets from the accepting edge (-1 = none).
  task automatic run(input longint ix, input longint iy, input longint iz,
                     input longint sg, input longint rh, input longint bt,
                     input longint dtv, input int ns, input int nexp,
                     input int abort_at, input int mid_at);
    int   e0, rel, limit;
    exp_t e;
    @(negedge clk);
    init_x = ix[W-1:0]; init_y = iy[W-1:0]; init_z = iz[W-1:0];
    sigma = sg[W-1:0]; rho = rh[W-1:0]; beta = bt[W-1:0]; dt = dtv[W-1:0];
    num_steps = ns[SW-1:0];
    abort = 1'b0;
    start = 1'b1;
    e0 = cyc + 1;
    msat = 1'b0;
    mx = ix; my = iy; mz = iz; msig = sg; mbet = bt; mdt = dtv;
    mrdt = fmul(rh, dtv);
    for (int n = 1; n <= nexp; n++) begin
      model_step();
      e.cyc = e0 + 1 + 8 * n;
      e.x = mx; e.y = my; e.z = mz;
      e.step = n;
      e.sat = msat;
      sbq.push_back(e);
    end
    if (ns != 0 && abort_at < 0) dq.push_back(e0 + 2 + 8 * ns);
    limit = (abort_at >= 0) ? abort_at + 4 : 8 * ns + 6;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("x_loaded", x_out, ix);
    chk("z_loaded", z_out, iz);
    chk("step_cleared", step_cnt, 0);
    rel = 0;
    while (rel < limit) begin
      @(negedge clk);
      rel = cyc - e0;
      if (abort_at >= 0 && rel == abort_at) abort = 1'b1;
      if (abort_at >= 0 && rel == abort_at + 1) begin
        abort = 1'b0;
        chk("idle_after_abort", busy, 0);
      end
      if (mid_at >= 0 && rel == mid_at) begin
        init_x = 27'h0700000;
        sigma  = 27'h0100000;
        start  = 1'b1;
      end
      if (mid_at >= 0 && rel == mid_at + 1) start = 1'b0;
    end
    chk("missing_out_valid", sbq.size(), 0);
    chk("missing_done", dq.size(), 0);
    chk("busy_at_end", busy, 0);
    sbq.delete();
    dq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_step", step_cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single step: x=1, y=2, z=3, sigma=10, rho=28, beta=2, dt=1/16.
    run(ONE, 2*ONE, 3*ONE, 10*ONE, 28*ONE, 2*ONE, ONE/16, 1, 1, -1, -1);
    chk("ss_x", x_out, 64'sh01A0000);
    chk("ss_y", y_out, 64'sh0370000);
    chk("ss_z", z_out, 64'sh02C0000);
    chk("ss_step", step_cnt, 1);
    chk("ss_sat", sat_flag, 0);

    // Five steps with a stray start pulse partway through.
    run(ONE, 2*ONE, 3*ONE, 10*ONE, 28*ONE, 2*ONE, ONE/16, 5, 5, -1, 12);
    chk("ms_step", step_cnt, 5);
    chk("ms_x_hold", x_out, mx);

    // Saturation: a-b and sigma*(a-b) both clamp, x lands on -4.0.
    run(60*ONE, -60*ONE, 0, 10*ONE, 28*ONE, 2*ONE, ONE, 1, 1, -1, -1);
    chk("sat_x", x_out, -64'sd4194304);
    chk("sat_y", y_out, 64'sd4194303);
    chk("sat_z", z_out, -64'sd67108864);
    chk("sat_flag_set", sat_flag, 1);
    repeat (5) @(negedge clk);
    chk("sat_flag_sticky", sat_flag, 1);

    // Abort during the UPD cycle of step 2 of 3: step 2 commits, no done.
    run(ONE, 2*ONE, 3*ONE, 10*ONE, 28*ONE, 2*ONE, ONE/16, 3, 2, 16, -1);
    chk("aupd_step", step_cnt, 2);
    chk("aupd_x", x_out, mx);
    chk("aupd_sat_cleared", sat_flag, 0);

    // Free-run, abort in MUL k2 of step 21: outputs hold the step-20 state.
    run(ONE, ONE, ONE, 10*ONE, 28*ONE, 64'sd2796202, ONE/256, 0, 20, 163, -1);
    chk("fr_step", step_cnt, 20);
    chk("fr_x", x_out, mx);
    chk("fr_y", y_out, my);
    chk("fr_z", z_out, mz);

    // Asynchronous reset in MUL k3.
    @(negedge clk);
    init_x = 27'h0100000; init_y = 27'h0200000; init_z = 27'h0300000;
    num_steps = 16'd1;
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_x", x_out, 0);
    chk("arst_y", y_out, 0);
    chk("arst_z", z_out, 0);
    chk("arst_step", step_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_sat", sat_flag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_x", x_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lorenz_stepper.md
# lorenz_stepper

Parametrised, time-multiplexed forward-Euler solver for the Lorenz system (x' = σ(y−x), y' = x(ρ−z)−y, z' = xy−βz) in signed fixed point. It replaces the fully parallel seven-multiplier integrator with a single shared signed multiplier sequenced by an FSM. It adds a start/busy/done handshake, a programmable step count with free-run, abort, and saturating arithmetic with a sticky overflow flag. It sits between the HPS-written parameter registers and the VGA/plot sample path, which consumes one `out_valid` sample per step.

## Interface
- `WIDTH`, 27: total bits of every state, parameter and product; two's complement.
- `FRAC`, 20: fractional bits. The default gives Q7.20, with range [−64, 64).
- `STEP_W`, 16: width of the step counter and `num_steps`.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE.
- `abort`  in  1  level; returns the block to IDLE from any state.
- `init_x`, `init_y`, `init_z`  in  WIDTH  initial state, latched on an accepted start.
- `sigma`, `beta`, `rho`, `dt`  in  WIDTH  coefficients, latched on an accepted start.
- `num_steps`  in  STEP_W  steps to run; 0 means free-run until abort.
- `x_out`, `y_out`, `z_out`  out  WIDTH  current state registers.
- `out_valid`  out  1  one-cycle pulse when a new state is registered.
- `busy`  out  1  high in PREP, MUL and UPD.
- `done`  out  1  one-cycle pulse on normal completion.
- `step_cnt`  out  STEP_W  completed steps in the current run.
- `sat_flag`  out  1  sticky; set on any saturation; cleared on an accepted start.

## Operation
- **Multiplier:** one signed WIDTH×WIDTH multiplier producing a 2·WIDTH-bit product.
  - The result is product bits [FRAC+WIDTH−1 : FRAC].
  - If the discarded upper bits are not all copies of the result sign bit, the result saturates to max/min and `sat_flag` is set.
- **Add/subtract:** all additions and subtractions are WIDTH-bit and saturating. Overflow clamps to 2^(WIDTH−1)−1 or −2^(WIDTH−1) and sets `sat_flag`.
- **States:** IDLE, PREP, MUL (sub-index k = 0..6), UPD, DONE.
- **IDLE:**
  - With `start`=1 and `abort`=0: latch the inputs, load x/y/z from `init_*`, clear `step_cnt` and `sat_flag`, go to PREP.
  - Otherwise hold.
- **PREP:** compute rdt = ρ·dt once per run, then go to MUL k=0.
- **MUL:** one product per cycle, each registered. State operands are the values at the start of the step.
  - k0: a = y·dt
  - k1: b = x·dt
  - k2: c = z·dt
  - k3: dx = σ·(a−b)
  - k4: p = x·(rdt−c)
  - k5: q = x·a
  - k6: r = β·c
  - After k6, go to UPD.
- **UPD:**
  - Register x += dx, y += (p−a), z += (q−r).
  - Increment `step_cnt`, with wrap-around at 2^STEP_W in free-run.
  - Pulse `out_valid`.
  - If `num_steps`≠0 and the new `step_cnt` equals `num_steps`, go to DONE; otherwise go to MUL k=0.
- **DONE:** pulse `done` for one cycle, then return to IDLE.
- **Start while busy:** ignored. Latched coefficients do not change mid-run.
- **Abort:** from any non-IDLE state, go to IDLE on the next edge.
  - x/y/z and `step_cnt` hold their last registered values.
  - No `done` pulse. If abort coincides with UPD, that update still commits.
- **Abort and start together in IDLE:** abort wins; the start is not accepted.

## Timing
- **Reset values:**
  - x/y/z_out = 0, `step_cnt` = 0.
  - `out_valid`, `busy`, `done`, `sat_flag` = 0.
  - State = IDLE.
- **Start accepted at edge E0:**
  - `init_*` visible on the outputs and `busy`=1 from E0.
  - PREP occupies one cycle, MUL seven cycles, UPD one cycle.
  - First updated state and `out_valid` are visible after edge E0+9.
- **Steady state:** 8 cycles per step, so step n is visible after E0+1+8n.
- **Completion:** `done` is high in the cycle after the final `out_valid`. `busy` falls in the same cycle `done` rises.
- **Restart:** earliest re-start is accepted 2 cycles after the final `out_valid` edge.

## Test plan
- **Reset:** assert `reset_n`=0 mid-MUL (k3) → all outputs 0 immediately; IDLE after release; no `out_valid`.
- **Single step:** x=1.0 (0x0100000), y=2.0, z=3.0, σ=10, ρ=28, β=2, dt=0.0625, `num_steps`=1 → one `out_valid` at E0+9 with x=1.625 (0x01A0000), y=3.4375 (0x0370000), z=2.75 (0x02C0000); `done` one cycle later; `step_cnt`=1.
- **Multi-step cadence:** same setup, `num_steps`=5 → `out_valid` at E0+9, 17, 25, 33, 41; values match a bit-exact Q7.20 software model; a `start` pulsed mid-run is ignored.
- **Saturation:** x=60, y=−60, z=0, σ=10, dt=1.0, `num_steps`=1 → (a−b) clamps to −64, dx clamps to −64, x=−4.0, `sat_flag`=1; the flag stays set until the next start.
- **Free-run and abort:** `num_steps`=0 → `out_valid` every 8 cycles past 20 steps; assert `abort` during MUL k2 → IDLE next cycle, outputs hold the step-20 values, no `done`.
- **Abort in UPD:** assert `abort` in the UPD cycle → the update commits with `out_valid`=1, then IDLE, no `done`.
